// File: rtl/blit_rect_gen.sv
// -----------------------------------------------------------------------------
// blit_rect_gen
//
// Purpose:
//   Walks a destination rectangle in raster order and emits one byte-pixel
//   (address + data) per non-stalled cycle.
//
//   This block is the upstream producer for blit_combine. It drives the
//   combiner's in_data / in_addr / in_en / in_active inputs directly and shares
//   the combiner's stall, so the pair advances in lockstep. out_active drops at
//   the end of each blit so the combiner flushes its partial word.
//
// Sequence:
//   IDLE -> (RUN) -> FLUSH -> DONE -> IDLE
//   A zero width or zero height skips RUN, so no pixels are emitted.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset; aborts a blit immediately
//                (no flush and no done pulse)
//   stall        downstream stall; freezes every register, including done
//   start        one-cycle blit request; sampled only in IDLE with stall low
//   dest_addr    byte address of the top-left pixel
//   dest_stride  bytes between row starts (zero-extended)
//   width        pixels per row
//   height       row count
//   fg_color     fill colour
//   pattern      (BLIT_RECT_GEN_PATTERN_EN only) 8x8 tile mask, bit {y,x}
//   bg_color     (BLIT_RECT_GEN_PATTERN_EN only) colour used where mask is 0
//   out_data     pixel byte          -> combiner in_data
//   out_addr     pixel byte address  -> combiner in_addr
//   out_en       pixel valid         -> combiner in_en
//   out_active   blit in progress    -> combiner in_active
//   busy         high from start acceptance until done
//   done         one-cycle completion pulse
//
// Optional feature:
//   Define BLIT_RECT_GEN_PATTERN_EN to add the pattern / bg_color ports. Each
//   pixel is then fg_color where pattern[{y[2:0],x[2:0]}] is set and bg_color
//   otherwise, i.e. an 8x8 tile anchored at the rectangle's top-left corner.
//   Timing and handshakes do not change.
//
// Address arithmetic is modulo 2^ADDR_W; wrapping past the top of memory is
// legal and not flagged.
// -----------------------------------------------------------------------------
module blit_rect_gen #(
    parameter int ADDR_W   = 26,
    parameter int DIM_W    = 12,
    parameter int STRIDE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                start,
    input  logic [ADDR_W-1:0]   dest_addr,
    input  logic [STRIDE_W-1:0] dest_stride,
    input  logic [DIM_W-1:0]    width,
    input  logic [DIM_W-1:0]    height,
    input  logic [7:0]          fg_color,
`ifdef BLIT_RECT_GEN_PATTERN_EN
    input  logic [63:0]         pattern,
    input  logic [7:0]          bg_color,
`endif
    output logic [7:0]          out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_en,
    output logic                out_active,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;

    // Parameters of the blit in progress, captured when start is accepted
    logic [STRIDE_W-1:0] stride_r;
    logic [DIM_W-1:0]    width_r;
    logic [DIM_W-1:0]    height_r;
    logic [7:0]          fg_r;
`ifdef BLIT_RECT_GEN_PATTERN_EN
    logic [63:0]         pattern_r;
    logic [7:0]          bg_r;
    logic [5:0]          pix_idx_s;
`endif

    // Raster position; row_base_r is the address of pixel (0, y_r)
    logic [ADDR_W-1:0]   row_base_r;
    logic [DIM_W-1:0]    x_r;
    logic [DIM_W-1:0]    y_r;

    // Output registers
    logic [7:0]          out_data_r;
    logic [ADDR_W-1:0]   out_addr_r;
    logic                out_en_r;
    logic                out_active_r;
    logic                busy_r;
    logic                done_r;

    // Combinational helpers for the RUN step
    logic                last_col_s;
    logic                last_row_s;
    logic                zero_size_s;
    logic [ADDR_W-1:0]   pix_addr_s;
    logic [ADDR_W-1:0]   next_base_s;
    logic [7:0]          pix_data_s;

    // Current-pixel address/colour and end-of-row / end-of-rect detection
    always_comb begin
        last_col_s  = (x_r == (width_r - DIM_W'(1'b1)));
        last_row_s  = (y_r == (height_r - DIM_W'(1'b1)));
        zero_size_s = (width == {DIM_W{1'b0}}) || (height == {DIM_W{1'b0}});
        // x and the stride are unsigned, so the casts zero-extend them
        pix_addr_s  = row_base_r + ADDR_W'(x_r);
        next_base_s = row_base_r + ADDR_W'(stride_r);
`ifdef BLIT_RECT_GEN_PATTERN_EN
        pix_idx_s   = {y_r[2:0], x_r[2:0]};
        if (pattern_r[pix_idx_s]) begin
            pix_data_s = fg_r;
        end else begin
            pix_data_s = bg_r;
        end
`else
        pix_data_s  = fg_r;
`endif
    end

    // Blit sequencer: state, raster counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            stride_r     <= {STRIDE_W{1'b0}};
            width_r      <= {DIM_W{1'b0}};
            height_r     <= {DIM_W{1'b0}};
            fg_r         <= 8'h00;
`ifdef BLIT_RECT_GEN_PATTERN_EN
            pattern_r    <= 64'h0;
            bg_r         <= 8'h00;
`endif
            row_base_r   <= {ADDR_W{1'b0}};
            x_r          <= {DIM_W{1'b0}};
            y_r          <= {DIM_W{1'b0}};
            out_data_r   <= 8'h00;
            out_addr_r   <= {ADDR_W{1'b0}};
            out_en_r     <= 1'b0;
            out_active_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (!stall) begin
            case (state_r)
                ST_IDLE: begin
                    done_r       <= 1'b0;
                    out_en_r     <= 1'b0;
                    out_active_r <= 1'b0;
                    if (start) begin
                        stride_r   <= dest_stride;
                        width_r    <= width;
                        height_r   <= height;
                        fg_r       <= fg_color;
`ifdef BLIT_RECT_GEN_PATTERN_EN
                        pattern_r  <= pattern;
                        bg_r       <= bg_color;
`endif
                        row_base_r <= dest_addr;
                        x_r        <= {DIM_W{1'b0}};
                        y_r        <= {DIM_W{1'b0}};
                        busy_r     <= 1'b1;
                        // An empty rectangle still flushes and pulses done
                        if (zero_size_s) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    out_addr_r   <= pix_addr_s;
                    out_data_r   <= pix_data_s;
                    out_en_r     <= 1'b1;
                    out_active_r <= 1'b1;
                    if (last_col_s) begin
                        // Row step lands in the same cycle, so no bubble at
                        // the row boundary
                        x_r        <= {DIM_W{1'b0}};
                        y_r        <= y_r + DIM_W'(1'b1);
                        row_base_r <= next_base_s;
                        if (last_row_s) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        x_r     <= x_r + DIM_W'(1'b1);
                        state_r <= ST_RUN;
                    end
                end

                ST_FLUSH: begin
                    // Dropping out_active makes the combiner write its
                    // partial word; address/data keep their last values
                    out_en_r     <= 1'b0;
                    out_active_r <= 1'b0;
                    state_r      <= ST_DONE;
                end

                ST_DONE: begin
                    done_r       <= 1'b1;
                    busy_r       <= 1'b0;
                    out_en_r     <= 1'b0;
                    out_active_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end

                default: begin
                    state_r      <= ST_IDLE;
                    out_en_r     <= 1'b0;
                    out_active_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = out_data_r;
    assign out_addr   = out_addr_r;
    assign out_en     = out_en_r;
    assign out_active = out_active_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_blit_rect_gen.sv
// -----------------------------------------------------------------------------
// tb_blit_rect_gen
//
// Scoreboard bench for blit_rect_gen. The stimulus thread pushes the expected
// pixels (address, data) and expected done pulses before each blit. A monitor
// running on the falling clock edge pops and compares every pixel the DUT hands
// over (out_en high and stall low) and every done pulse. The stimulus thread
// also checks reset values, busy length, flush placement, stall hold and
// reset abort.
// -----------------------------------------------------------------------------
module tb_blit_rect_gen;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        start;
    logic [25:0] dest_addr;
    logic [15:0] dest_stride;
    logic [11:0] width;
    logic [11:0] height;
    logic [7:0]  fg_color;
`ifdef BLIT_RECT_GEN_PATTERN_EN
    logic [63:0] pattern;
    logic [7:0]  bg_color;
`endif
    logic [7:0]  out_data;
    logic [25:0] out_addr;
    logic        out_en;
    logic        out_active;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [25:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    int          done_pending;

    logic [25:0] mon_addr;
    logic [7:0]  mon_data;

    blit_rect_gen #(
        .ADDR_W  (26),
        .DIM_W   (12),
        .STRIDE_W(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .start      (start),
        .dest_addr  (dest_addr),
        .dest_stride(dest_stride),
        .width      (width),
        .height     (height),
        .fg_color   (fg_color),
`ifdef BLIT_RECT_GEN_PATTERN_EN
        .pattern    (pattern),
        .bg_color   (bg_color),
`endif
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_en     (out_en),
        .out_active (out_active),
        .busy       (busy),
        .done       (done)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something never terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pixel is handed over on every cycle with out_en and no stall
    always @(negedge clock) begin
        if (!reset && out_en && !stall) begin
            chk("pixel_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                chk("pixel_addr", 64'(out_addr), 64'(mon_addr));
                chk("pixel_data", 64'(out_data), 64'(mon_data));
            end
        end
        if (!reset && done && !stall) begin
            chk("done_expected", 64'(done_pending > 0), 64'd1);
            if (done_pending > 0) begin
                done_pending--;
            end
        end
    end

    // Reference: pixel (x,y) sits at base + y*stride + x, modulo 2^26
    task automatic push_rect(input logic [25:0] base, input logic [15:0] strd,
                             input int w, input int h, input logic [7:0] col);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_addr_q.push_back(base + 26'(y) * 26'(strd) + 26'(x));
                exp_data_q.push_back(col);
            end
        end
        done_pending++;
    endtask

    // Called at posedge+1; start is accepted at the next rising edge
    task automatic start_blit(input logic [25:0] a, input logic [15:0] s,
                              input logic [11:0] w, input logic [11:0] h,
                              input logic [7:0] c);
        dest_addr   = a;
        dest_stride = s;
        width       = w;
        height      = h;
        fg_color    = c;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
    endtask

    // Observes cycles n = 1, 2, ... after the accepting edge. Stall is held
    // for n in [st_lo, st_hi]; start is re-pulsed at n == restart_at; reset is
    // asserted at n == rst_at. Reports busy length, the cycle done appears in,
    // and out_active in the two cycles before done.
    task automatic observe(input int st_lo, input int st_hi, input logic [25:0] hold_addr,
                           input int restart_at, input int rst_at,
                           output int busy_cnt, output int done_n,
                           output logic flush_act, output logic last_act);
        logic p1;
        logic p2;
        p1        = 1'b0;
        p2        = 1'b0;
        busy_cnt  = 0;
        done_n    = 0;
        flush_act = 1'b1;
        last_act  = 1'b0;
        for (int n = 1; n < 64; n++) begin
            stall = (n >= st_lo) && (n <= st_hi);
            start = (n == restart_at);
            if (n == restart_at) begin
                dest_addr = 26'h0005000;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_abort_out_active", 64'(out_active), 64'd0);
                chk("rst_abort_busy", 64'(busy), 64'd0);
                chk("rst_abort_out_en", 64'(out_en), 64'd0);
                chk("rst_abort_done", 64'(done), 64'd0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                break;
            end
            @(negedge clock);
            if (stall) begin
                chk("stall_hold_addr", 64'(out_addr), 64'(hold_addr));
                chk("stall_hold_en", 64'(out_en), 64'd1);
            end
            if (busy) begin
                busy_cnt++;
            end
            if (done && done_n == 0) begin
                done_n    = n;
                flush_act = p1;
                last_act  = p2;
            end
            p2 = p1;
            p1 = out_active;
            @(posedge clock);
            #1;
            if (done_n != 0 && !stall) begin
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    int   busy_cnt;
    int   done_n;
    logic flush_act;
    logic last_act;

    initial begin
        checks       = 0;
        errors       = 0;
        done_pending = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        start        = 1'b0;
        dest_addr    = 26'h0;
        dest_stride  = 16'h0;
        width        = 12'h0;
        height       = 12'h0;
        fg_color     = 8'h00;
`ifdef BLIT_RECT_GEN_PATTERN_EN
        pattern      = 64'hFFFF_FFFF_FFFF_FFFF;
        bg_color     = 8'h00;
`endif

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_en", 64'(out_en), 64'd0);
        chk("reset_out_active", 64'(out_active), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_out_addr", 64'(out_addr), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic fill: 0x1000..0x1003, 0x1140..0x1143, data 0xAA
        push_rect(26'h0001000, 16'h0140, 4, 2, 8'hAA);
        start_blit(26'h0001000, 16'h0140, 12'd4, 12'd2, 8'hAA);
        observe(0, -1, 26'h0, 0, 0, busy_cnt, done_n, flush_act, last_act);
        chk("basic_busy_cycles", 64'(busy_cnt), 64'd10);
        chk("basic_done_cycle", 64'(done_n), 64'd11);
        chk("basic_flush_active", 64'(flush_act), 64'd0);
        chk("basic_last_pixel_active", 64'(last_act), 64'd1);
        @(posedge clock);
        #1;

        // Stall for 3 cycles once the second pixel (0x1001) is showing
        push_rect(26'h0001000, 16'h0140, 4, 2, 8'hAA);
        start_blit(26'h0001000, 16'h0140, 12'd4, 12'd2, 8'hAA);
        observe(3, 5, 26'h0001001, 0, 0, busy_cnt, done_n, flush_act, last_act);
        chk("stall_busy_cycles", 64'(busy_cnt), 64'd13);
        chk("stall_done_cycle", 64'(done_n), 64'd14);
        chk("stall_flush_active", 64'(flush_act), 64'd0);
        @(posedge clock);
        #1;

        // Zero size: no pixels, flush, done two cycles after acceptance
        push_rect(26'h0002000, 16'h0040, 0, 5, 8'h11);
        start_blit(26'h0002000, 16'h0040, 12'd0, 12'd5, 8'h11);
        observe(0, -1, 26'h0, 0, 0, busy_cnt, done_n, flush_act, last_act);
        chk("zero_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("zero_done_cycle", 64'(done_n), 64'd3);
        chk("zero_flush_active", 64'(flush_act), 64'd0);
        @(posedge clock);
        #1;

        // Address wrap past the top of memory
        exp_addr_q.push_back(26'h3FFFFFE); exp_data_q.push_back(8'h3C);
        exp_addr_q.push_back(26'h3FFFFFF); exp_data_q.push_back(8'h3C);
        exp_addr_q.push_back(26'h0000000); exp_data_q.push_back(8'h3C);
        exp_addr_q.push_back(26'h0000001); exp_data_q.push_back(8'h3C);
        done_pending++;
        start_blit(26'h3FFFFFE, 16'h0010, 12'd4, 12'd1, 8'h3C);
        observe(0, -1, 26'h0, 0, 0, busy_cnt, done_n, flush_act, last_act);
        chk("wrap_busy_cycles", 64'(busy_cnt), 64'd6);
        chk("wrap_done_cycle", 64'(done_n), 64'd7);
        @(posedge clock);
        #1;

        // Ignored start at n=3, reset at n=7 (second pixel of row 1 pending).
        // Pixels handed over before reset: 0x2000..0x2003 and 0x2100.
        exp_addr_q.push_back(26'h0002000); exp_data_q.push_back(8'h5A);
        exp_addr_q.push_back(26'h0002001); exp_data_q.push_back(8'h5A);
        exp_addr_q.push_back(26'h0002002); exp_data_q.push_back(8'h5A);
        exp_addr_q.push_back(26'h0002003); exp_data_q.push_back(8'h5A);
        exp_addr_q.push_back(26'h0002100); exp_data_q.push_back(8'h5A);
        start_blit(26'h0002000, 16'h0100, 12'd4, 12'd2, 8'h5A);
        observe(0, -1, 26'h0, 3, 7, busy_cnt, done_n, flush_act, last_act);
        repeat (4) @(posedge clock);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_out_active", 64'(out_active), 64'd0);
        chk("post_rst_pixels_left", 64'(exp_addr_q.size()), 64'd0);

`ifdef BLIT_RECT_GEN_PATTERN_EN
        // Pattern tile: only bit 0 set, so only pixel (0,0) is foreground
        pattern  = 64'h1;
        bg_color = 8'h00;
        exp_addr_q.push_back(26'h0000100); exp_data_q.push_back(8'hFF);
        exp_addr_q.push_back(26'h0000101); exp_data_q.push_back(8'h00);
        exp_addr_q.push_back(26'h0000110); exp_data_q.push_back(8'h00);
        exp_addr_q.push_back(26'h0000111); exp_data_q.push_back(8'h00);
        done_pending++;
        start_blit(26'h0000100, 16'h0010, 12'd2, 12'd2, 8'hFF);
        observe(0, -1, 26'h0, 0, 0, busy_cnt, done_n, flush_act, last_act);
        chk("pattern_busy_cycles", 64'(busy_cnt), 64'd6);
        @(posedge clock);
        #1;
`endif

        repeat (3) @(posedge clock);
        #1;
        chk("final_pixels_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("final_done_drained", 64'(done_pending), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
